// File: rtl/bitcoin_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bitcoin_pkg
//  Purpose  : Shared types and widths for the miner result path.
//             - scan_state_t : scanner FSM state encoding
//             - NUM_NONCES_DEF : default number of hash words per scan
//             - MEM_AW / WORD_W : result memory address / data widths
//  Revision : 1.0  initial release
// ============================================================================
package bitcoin_pkg;

  localparam int NUM_NONCES_DEF = 16;
  localparam int MEM_AW         = 16;
  localparam int WORD_W         = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/nonce_result_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module   : nonce_result_scanner_if
//  Purpose  : Single-port result memory bus between the scanner (master)
//             and the result RAM (slave).
//  Signals  : mem_clk       - memory clock (forwarded system clock)
//             mem_we        - write enable (held low by the scanner)
//             mem_addr      - read address
//             mem_read_data - read data returned by the RAM
//  Revision : 1.0  initial release
// ============================================================================
interface nonce_result_scanner_if;
  import bitcoin_pkg::*;

  logic              mem_clk;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [WORD_W-1:0] mem_read_data;

  modport master (
    output mem_clk,
    output mem_we,
    output mem_addr,
    input  mem_read_data
  );

  modport slave (
    input  mem_clk,
    input  mem_we,
    input  mem_addr,
    output mem_read_data
  );

endinterface
`default_nettype wire

// File: rtl/hash_min_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : hash_min_tracker
//  Purpose  : Accumulates per-nonce hit flags (hash < target, unsigned) and
//             the running minimum hash with its nonce index.
//  Ports    : clk, reset_n     - clock, async active-low reset
//             clear            - restart accumulation (new scan)
//             cap_valid        - cap_data is hash word cap_index
//             cap_index        - nonce index of cap_data
//             cap_data         - hash word
//             target           - latched threshold
//             hit_mask         - bit i set when hash[i] < target
//             min_hash         - smallest hash seen since clear
//             min_nonce        - index of min_hash (lowest index on ties)
//  Revision : 1.0  initial release
// ============================================================================
module hash_min_tracker
  import bitcoin_pkg::*;
#(
  parameter  int NUM_NONCES = NUM_NONCES_DEF,
  localparam int IW         = $clog2(NUM_NONCES)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  cap_valid,
  input  logic [IW-1:0]         cap_index,
  input  logic [WORD_W-1:0]     cap_data,
  input  logic [WORD_W-1:0]     target,
  output logic [NUM_NONCES-1:0] hit_mask,
  output logic [WORD_W-1:0]     min_hash,
  output logic [IW-1:0]         min_nonce
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_mask  <= '0;
      min_hash  <= '1;
      min_nonce <= '0;
    end else if (clear) begin
      hit_mask  <= '0;
      min_hash  <= '1;
      min_nonce <= '0;
    end else if (cap_valid) begin
      hit_mask[cap_index] <= (cap_data < target);
      // Strict compare: an equal later word never displaces an earlier one,
      // so ties resolve to the lowest index because words arrive in order.
      if (cap_data < min_hash) begin
        min_hash  <= cap_data;
        min_nonce <= cap_index;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/nonce_result_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : nonce_result_scanner
//  Purpose  : Reads NUM_NONCES hash words back from the result memory,
//             flags those below target and reports first hit and minimum.
//  Ports    : clk, reset_n   - clock, async active-low reset
//             start          - one-cycle scan request (taken only when idle)
//             result_addr    - base address of hash word 0
//             target         - unsigned hit threshold (hash < target)
//             mem            - result memory bus (master side)
//             done           - one-cycle pulse, results valid
//             busy           - scan in progress
//             hit_mask       - per-nonce hit flags
//             found          - any hit
//             first_nonce    - lowest hit index (0 if none)
//             min_hash       - smallest hash read
//             min_nonce      - index of min_hash
//  Revision : 1.0  initial release
// ============================================================================
module nonce_result_scanner
  import bitcoin_pkg::*;
#(
  parameter  int NUM_NONCES = NUM_NONCES_DEF,
  parameter  int READ_LAT   = 2,
  localparam int IW         = $clog2(NUM_NONCES)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [MEM_AW-1:0]           result_addr,
  input  logic [WORD_W-1:0]           target,
  nonce_result_scanner_if.master      mem,
  output logic                        done,
  output logic                        busy,
  output logic [NUM_NONCES-1:0]       hit_mask,
  output logic                        found,
  output logic [IW-1:0]               first_nonce,
  output logic [WORD_W-1:0]           min_hash,
  output logic [IW-1:0]               min_nonce
);

  localparam logic [IW-1:0] c_last_idx = IW'(NUM_NONCES - 1);

  scan_state_t         r_state;
  logic [MEM_AW-1:0]   r_base;
  logic [MEM_AW-1:0]   r_addr;
  logic [WORD_W-1:0]   r_target;
  logic [IW-1:0]       r_issue_cnt;
  logic [IW-1:0]       r_cap_cnt;
  logic [READ_LAT-1:0] r_rd_pipe;
  logic                r_smp_vld;
  logic [IW-1:0]       r_smp_idx;
  logic [WORD_W-1:0]   r_smp_data;
  logic                r_last_seen;

  logic                w_accept;
  logic                w_issue;
  logic                w_cap;
  logic [IW-1:0]       w_first;

  assign mem.mem_clk  = clk;
  assign mem.mem_we   = 1'b0;
  assign mem.mem_addr = r_addr;

  assign w_accept = (r_state == ST_IDLE) && start;
  // An address goes out on the accept edge and on every SCAN edge.
  assign w_issue  = w_accept || (r_state == ST_SCAN);
  // Issue markers travel READ_LAT edges so capture lines up with the data.
  assign w_cap    = r_rd_pipe[READ_LAT-1];

  generate
    if (READ_LAT == 1) begin : g_lat_one
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rd_pipe <= '0;
        else          r_rd_pipe <= w_issue;
      end
    end else begin : g_lat_multi
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rd_pipe <= '0;
        else          r_rd_pipe <= {r_rd_pipe[READ_LAT-2:0], w_issue};
      end
    end
  endgenerate

  // Capture stage: register the returned word with its index before the
  // compare so the comparators see a clean registered operand.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cap_cnt   <= '0;
      r_smp_vld   <= 1'b0;
      r_smp_idx   <= '0;
      r_smp_data  <= '0;
      r_last_seen <= 1'b0;
    end else begin
      r_smp_vld <= w_cap;
      if (w_accept) begin
        r_cap_cnt <= '0;
      end else if (w_cap) begin
        r_smp_idx  <= r_cap_cnt;
        r_smp_data <= mem.mem_read_data;
        r_cap_cnt  <= r_cap_cnt + 1'b1;
      end
      if (w_accept)
        r_last_seen <= 1'b0;
      else if (r_smp_vld && (r_smp_idx == c_last_idx))
        r_last_seen <= 1'b1;
    end
  end

  hash_min_tracker #(
    .NUM_NONCES (NUM_NONCES)
  ) u_tracker (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (w_accept),
    .cap_valid (r_smp_vld),
    .cap_index (r_smp_idx),
    .cap_data  (r_smp_data),
    .target    (r_target),
    .hit_mask  (hit_mask),
    .min_hash  (min_hash),
    .min_nonce (min_nonce)
  );

  // Lowest set bit wins: scan downward so the last assignment is the lowest.
  always_comb begin
    w_first = '0;
    for (int i = NUM_NONCES - 1; i >= 0; i--) begin
      if (hit_mask[i]) w_first = IW'(i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      done        <= 1'b0;
      busy        <= 1'b0;
      r_base      <= '0;
      r_addr      <= '0;
      r_target    <= '0;
      r_issue_cnt <= '0;
      found       <= 1'b0;
      first_nonce <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_base      <= result_addr;
            r_target    <= target;
            r_addr      <= result_addr;
            r_issue_cnt <= IW'(1);
            busy        <= 1'b1;
            found       <= 1'b0;
            first_nonce <= '0;
            r_state     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          // Address arithmetic wraps modulo the memory size.
          r_addr      <= r_base + MEM_AW'(r_issue_cnt);
          r_issue_cnt <= r_issue_cnt + 1'b1;
          if (r_issue_cnt == c_last_idx) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (r_last_seen) begin
            done        <= 1'b1;
            busy        <= 1'b0;
            found       <= |hit_mask;
            first_nonce <= w_first;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nonce_result_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_nonce_result_scanner
//  Purpose  : Self-checking bench for nonce_result_scanner with a result RAM
//             model (two-edge read latency) and a behavioural reference.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nonce_result_scanner;
  import bitcoin_pkg::*;

  localparam int N        = 16;
  localparam int LAT_DONE = N + 2 + 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] result_addr = '0;
  logic [31:0] target = '0;
  logic        done, busy, found;
  logic [N-1:0] hit_mask;
  logic [3:0]  first_nonce, min_nonce;
  logic [31:0] min_hash;

  nonce_result_scanner_if mem_if();

  nonce_result_scanner #(
    .NUM_NONCES (N),
    .READ_LAT   (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .result_addr (result_addr),
    .target      (target),
    .mem         (mem_if),
    .done        (done),
    .busy        (busy),
    .hit_mask    (hit_mask),
    .found       (found),
    .first_nonce (first_nonce),
    .min_hash    (min_hash),
    .min_nonce   (min_nonce)
  );

  always #5 clk = ~clk;

  // Result RAM: registered read, so data is sampled two edges after the
  // address register updates.
  logic [31:0] mem [0:65535];
  logic [31:0] rd_q;
  always @(posedge clk) rd_q <= mem[mem_if.mem_addr];
  assign mem_if.mem_read_data = rd_q;

  int errors = 0;
  int checks = 0;
  int pin_sel = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          age = -1;     // edges since accepted start, -1 when idle
  logic        have = 1'b0;  // a completed result is on the outputs
  int          m_pin = 0;
  logic [15:0] m_base = '0;
  logic [15:0] m_addr = '0;
  logic [N-1:0] e_hm;
  logic        e_found;
  logic [3:0]  e_first, e_mn;
  logic [31:0] e_min;

  task automatic model_accept();
    logic [31:0] w;
    logic [31:0] tgt;
    logic        seen;
    m_base = result_addr;
    tgt    = target;
    m_pin  = pin_sel;
    e_hm   = '0;
    e_min  = 32'hFFFF_FFFF;
    for (int i = 0; i < N; i++) begin
      w = mem[m_base + 16'(i)];
      e_hm[i] = (w < tgt);
      if (w < e_min) e_min = w;
    end
    e_found = (e_hm != '0);
    e_first = '0;
    e_mn    = '0;
    seen    = 1'b0;
    for (int i = N - 1; i >= 0; i--) if (e_hm[i]) e_first = 4'(i);
    for (int i = 0; i < N; i++) begin
      if (!seen && mem[m_base + 16'(i)] == e_min) begin
        e_mn = 4'(i);
        seen = 1'b1;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (reset_n) begin
        if (age >= 0) begin
          age++;
          if (age == LAT_DONE + 1) age = -1;
        end else if (start) begin
          model_accept();
          age  = 0;
          have = 1'b0;
        end
        if (age >= 0 && age < N) m_addr = m_base + 16'(age);
        if (age == LAT_DONE) have = 1'b1;
      end
      @(negedge clk);
      if (!reset_n) begin
        age    = -1;
        have   = 1'b0;
        m_addr = '0;
      end
      check("mem_we",  64'(mem_if.mem_we), 64'(0));
      check("mem_clk", 64'(mem_if.mem_clk), 64'(clk));
      check("busy",    64'(busy), 64'(age >= 0 && age < LAT_DONE));
      check("done",    64'(done), 64'(age == LAT_DONE));
      check("mem_addr", 64'(mem_if.mem_addr), 64'(m_addr));
      if (age >= 0 && age < LAT_DONE) begin
        check("found_cleared", 64'(found), 64'(0));
        check("first_cleared", 64'(first_nonce), 64'(0));
      end
      if (age == 0 || age == 1) begin
        check("hit_mask_cleared", 64'(hit_mask), 64'(0));
        check("min_hash_cleared", 64'(min_hash), 64'(32'hFFFF_FFFF));
        check("min_nonce_cleared", 64'(min_nonce), 64'(0));
      end
      if (age == LAT_DONE || age == -1) begin
        if (have) begin
          check("hit_mask",    64'(hit_mask),    64'(e_hm));
          check("found",       64'(found),       64'(e_found));
          check("first_nonce", 64'(first_nonce), 64'(e_first));
          check("min_hash",    64'(min_hash),    64'(e_min));
          check("min_nonce",   64'(min_nonce),   64'(e_mn));
        end else begin
          check("rst_hit_mask",    64'(hit_mask),    64'(0));
          check("rst_found",       64'(found),       64'(0));
          check("rst_first_nonce", 64'(first_nonce), 64'(0));
          check("rst_min_hash",    64'(min_hash),    64'(32'hFFFF_FFFF));
          check("rst_min_nonce",   64'(min_nonce),   64'(0));
        end
      end
      // Hand-computed results for the directed scenarios.
      if (age == LAT_DONE) begin
        case (m_pin)
          1: begin
            check("t1_hit_mask", 64'(hit_mask), 64'(16'h0007));
            check("t1_found",    64'(found),    64'(1));
            check("t1_first",    64'(first_nonce), 64'(0));
            check("t1_min_hash", 64'(min_hash), 64'(32'h0000_0005));
            check("t1_min_nonce", 64'(min_nonce), 64'(0));
          end
          2: begin
            check("t2_hit_mask", 64'(hit_mask), 64'(0));
            check("t2_found",    64'(found),    64'(0));
            check("t2_min_hash", 64'(min_hash), 64'(32'hFFFF_FFFF));
            check("t2_min_nonce", 64'(min_nonce), 64'(0));
          end
          3: begin
            check("t3_hit_mask", 64'(hit_mask), 64'(16'h1200));
            check("t3_first",    64'(first_nonce), 64'(9));
            check("t3_min_hash", 64'(min_hash), 64'(32'h0000_0010));
            check("t3_min_nonce", 64'(min_nonce), 64'(9));
          end
          4: check("t4_last_addr", 64'(mem_if.mem_addr), 64'(16'h0007));
          default: ;
        endcase
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 1: extra start plus target/base change mid-scan
  // mode 2: start raised in the cycle done is high
  task automatic run_scan(input logic [15:0] base, input logic [31:0] tgt,
                          input int pin, input int mode);
    result_addr = base;
    target      = tgt;
    pin_sel     = pin;
    start       = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= LAT_DONE + 2; k++) begin
      if (mode == 1 && k == 5) begin
        start       = 1'b1;
        target      = ~tgt;
        result_addr = base + 16'h0040;
      end
      if (mode == 1 && k == 6) start = 1'b0;
      if (mode == 2 && k == LAT_DONE + 1) start = 1'b1;
      if (mode == 2 && k == LAT_DONE + 2) start = 1'b0;
      tick();
    end
    pin_sel = 0;
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 3))
      0:       return 32'h0000_0010;
      1:       return 32'($urandom_range(0, 255));
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [31:0] rnd_target();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_0011;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [15:0] b;
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < N; i++) mem[16'h0100 + 16'(i)] = 32'(i) * 32'h1000_0000 + 32'd5;
    run_scan(16'h0100, 32'h3000_0000, 1, 0);

    for (int i = 0; i < N; i++) mem[16'h0200 + 16'(i)] = 32'hFFFF_FFFF;
    run_scan(16'h0200, 32'hFFFF_FFFF, 2, 0);

    for (int i = 0; i < N; i++)
      mem[16'h0300 + 16'(i)] = (i == 9 || i == 12) ? 32'h0000_0010 : 32'h8000_0000;
    run_scan(16'h0300, 32'h0000_0011, 3, 0);

    for (int i = 0; i < N; i++) mem[16'hFFF8 + 16'(i)] = rnd_word();
    run_scan(16'hFFF8, rnd_target(), 4, 0);

    run_scan(16'h0100, 32'h3000_0000, 1, 1);
    run_scan(16'h0300, 32'h0000_0011, 3, 2);

    // Abort a scan with reset, then scan again.
    result_addr = 16'h0100;
    target      = 32'h3000_0000;
    start       = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    run_scan(16'h0100, 32'h3000_0000, 1, 0);

    for (int r = 0; r < 10; r++) begin
      b = 16'($urandom());
      for (int i = 0; i < N; i++) mem[b + 16'(i)] = rnd_word();
      run_scan(b, rnd_target(), 0, int'($urandom_range(0, 2)));
      repeat ($urandom_range(0, 3)) tick();
    end

    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nonce_result_scanner.md
Name: nonce_result_scanner

Overview:
- Reader at the far end of the miner's result memory. After the hash engine has written NUM_NONCES 32-bit hash words to a base address, this block reads them back over the same single-port memory interface.
- Compares each word, unsigned, against a 32-bit target. Reports which nonces hit, the first hit, and the minimum hash with its nonce index.
- Sits between the hash core and the host/nonce-dispatch logic.

Parameters:
- NUM_NONCES, 16, number of consecutive hash words to scan (power of 2, 2..32).
- READ_LAT, 2, clock edges from mem_addr register update to mem_read_data sampling.
- IW, $clog2(NUM_NONCES), nonce index width (derived, not overridable).

Ports:
- clk  in  1  clock; also forwarded to mem_clk.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- result_addr  in  16  base address of hash word 0.
- target  in  32  unsigned threshold; hit when hash < target.
- mem_clk  out  1  equals clk.
- mem_we  out  1  constant 0 (read-only master).
- mem_addr  out  16  read address.
- mem_read_data  in  32  read data, valid READ_LAT edges after mem_addr changes.
- done  out  1  one-cycle pulse when results are valid.
- busy  out  1  high from start acceptance until done pulse.
- hit_mask  out  NUM_NONCES  bit i set when hash[i] < target.
- found  out  1  OR of hit_mask.
- first_nonce  out  IW  lowest set index of hit_mask; 0 if none.
- min_hash  out  32  smallest hash read.
- min_nonce  out  IW  index of min_hash; lowest index on ties.

Behaviour:
- Reset (async, any state): state=IDLE, done=0, busy=0, mem_we=0, mem_addr=0, hit_mask=0, found=0, first_nonce=0, min_hash=32'hFFFFFFFF, min_nonce=0, counters=0.
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - On start=1: latch result_addr and target; clear hit_mask; min_hash=FFFFFFFF; min_nonce=0; busy=1; mem_addr=result_addr; issue counter=1; go to SCAN.
- SCAN:
  - Each cycle, mem_addr <= latched_base + issue counter (mod 2^16, wraps), then issue counter++.
  - Leave for DRAIN once address NUM_NONCES-1 has been issued.
- Capture pipeline (runs in SCAN and DRAIN):
  - Capture counter c starts READ_LAT cycles after the first address.
  - On each capture edge, data is hash[c]:
    - hit_mask[c] <= (hash < latched target), unsigned, strict.
    - If hash < min_hash (strict), then min_hash <= hash and min_nonce <= c.
  - Word 0 always replaces the FFFFFFFF seed, or equals it.
  - Then c++.
- DRAIN: wait until c has captured NUM_NONCES-1, then go to DONE.
- DONE:
  - Assert done=1 for exactly one cycle; busy=0; update found and first_nonce from the final hit_mask; return to IDLE.
- Latency: the start sampling edge to the edge where done rises is NUM_NONCES+READ_LAT+1 cycles (19 at defaults).
- Result outputs hold their values after done until the next accepted start, which clears them on that edge.
- start while busy: ignored, no effect on the scan.
- start in the same cycle done is high: ignored (FSM is not yet IDLE).
- target and result_addr changing mid-scan: no effect (latched).
- mem_we is never asserted; mem_write_data is not driven by this block.
- Reset mid-scan: immediate abort; no done pulse.

Decomposition:
- Shared package bitcoin_pkg:
  - scanner state enum.
  - NUM_NONCES default.
  - MEM_AW=16.
  - WORD_W=32.
- One natural sub-module, hash_min_tracker:
  - Inputs: clear, capture valid, index, data, target.
  - Outputs: hit_mask, min_hash, min_nonce.
  - Parent keeps the FSM, address issue and the found/first_nonce priority encoder.

Test Plan:
1. Memory at base 16'h0100 holds words i*32'h1000_0000+5 (i=0..15); target=32'h3000_0000 -> hit_mask=16'h0007, found=1, first_nonce=0, min_hash=32'h0000_0005, min_nonce=0, done 19 cycles after start.
2. All words 32'hFFFF_FFFF, target=32'hFFFF_FFFF -> hit_mask=0, found=0, first_nonce=0, min_hash=FFFFFFFF, min_nonce=0.
3. Words 9 and 12 both 32'h0000_0010, all others 32'h8000_0000; target=32'h0000_0011 -> hit_mask=16'h1200, first_nonce=9, min_nonce=9 (tie keeps lower index).
4. result_addr=16'hFFF8 -> addresses FFF8..FFFF then 0000..0007 issued in order; mem_we stays 0 throughout.
5. Second start pulse and target change during SCAN -> ignored; results match the first request; exactly one done pulse.
6. reset_n low at cycle 8 of a scan, released, then a new start -> all outputs at reset values; no done from the aborted scan; the new scan completes correctly.
